// File: rtl/color_fsm_arbiter.sv
// Round-robin arbiter that shares one Mealy colour FSM among NUM_REQ requesters.
// Define COLOR_ARB_TIMEOUT_EN to revoke a grant after TIMEOUT consecutive stall cycles.
module color_fsm_arbiter #(
   parameter int                 NUM_REQ   = 4,
   parameter int                 CMD_W     = 2,
   parameter int                 MAX_BURST = 4,
   parameter logic [CMD_W-1:0]   IDLE_CMD  = '0,
   parameter int                 TIMEOUT   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*CMD_W-1:0]    req_cmd,
   input  logic [NUM_REQ-1:0]          req_last,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [CMD_W-1:0]            fsm_in,
   output logic                        fsm_in_valid,
   input  logic [CMD_W-1:0]            fsm_out,
   output logic                        rsp_valid,
   output logic [CMD_W-1:0]            rsp_data,
   output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        busy,
   output logic                        timeout_err
);

   localparam int ID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

   state_t            state, state_next;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   pick;
   logic [ID_W-1:0]   fsm_in_id;
   logic [3:0]        beat_cnt;
   logic              any_valid;
   logic              accept;
   logic              stall_hit;
   logic [CMD_W-1:0]  grant_cmd;
   logic              grant_last;

   // Walk downward so the candidate nearest rr_ptr+1 is written last and wins.
   always_comb begin
      pick      = rr_ptr;
      any_valid = |req_valid;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req_valid[(int'(rr_ptr) + k) % NUM_REQ])
            pick = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
   end

`ifdef COLOR_ARB_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT + 1);
   logic [STALL_W-1:0] stall_cnt;

   assign stall_hit = (state == GRANT) && !req_valid[grant_id] &&
                      (stall_cnt == STALL_W'(TIMEOUT - 1));

   // Counts consecutive stalled GRANT cycles; the revoke pulse lines up with DRAIN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt   <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= stall_hit;
         if (state != GRANT || req_valid[grant_id] || stall_hit)
            stall_cnt <= '0;
         else
            stall_cnt <= stall_cnt + STALL_W'(1);
      end
   end
`else
   assign stall_hit   = 1'b0;
   // TIMEOUT only matters when the revoke option is built in.
   assign timeout_err = (TIMEOUT < 0);
`endif

   always_comb begin
      state_next = state;
      req_ready  = '0;
      accept     = 1'b0;
      grant_cmd  = req_cmd[int'(grant_id)*CMD_W +: CMD_W];
      grant_last = req_last[grant_id];
      case (state)
         IDLE: begin
            if (any_valid)
               state_next = GRANT;
         end
         GRANT: begin
            req_ready[grant_id] = 1'b1;
            accept              = req_valid[grant_id];
            if (accept && (grant_last || (beat_cnt + 4'd1 == 4'(MAX_BURST))))
               state_next = DRAIN;
            if (stall_hit)
               state_next = DRAIN;
         end
         DRAIN: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Beat pipeline: accepted command lands on fsm_in, its Mealy output is captured one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr       <= ID_W'(NUM_REQ - 1);
         grant_id     <= '0;
         beat_cnt     <= '0;
         fsm_in       <= IDLE_CMD;
         fsm_in_valid <= 1'b0;
         fsm_in_id    <= '0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         rsp_id       <= '0;
      end else begin
         fsm_in       <= accept ? grant_cmd : IDLE_CMD;
         fsm_in_valid <= accept;
         if (accept) begin
            fsm_in_id <= grant_id;
            beat_cnt  <= beat_cnt + 4'd1;
         end
         rsp_valid <= fsm_in_valid;
         if (fsm_in_valid) begin
            rsp_data <= fsm_out;
            rsp_id   <= fsm_in_id;
         end
         if (state == IDLE && any_valid) begin
            grant_id <= pick;
            beat_cnt <= '0;
         end
         if (state == DRAIN)
            rr_ptr <= grant_id;
      end
   end

   assign busy = (state != IDLE);

endmodule
